// File: rtl/rcs_word_arbiter.sv
// Round-robin arbiter publishing one requester's 28-bit payload + ID into a shared 32-bit register word.
// Latency: req high in IDLE at cycle T -> gnt pulse and new user_data_out at T+1; word held HOLD_CYCLES+2 cycles.
// Backpressure: requesters hold req/data until their gnt pulse; req is ignored while busy (LOAD/HOLD).
//
// Ports:
//   user_clk, user_rst_n       : clock, asynchronous active-low reset
//   req[N_REQ]                 : per-requester level request
//   req_data[N_REQ*28]         : packed payloads, requester i at [28*i +: 28]
//   gnt[N_REQ]                 : one-hot single-cycle grant (LOAD cycle only)
//   busy                       : high while in LOAD or HOLD
//   user_data_out[32]          : {seq[1:0], id[1:0], payload[27:0]}
// Optional feature: define RCS_ARB_SEQ_EN to carry a wrapping 2-bit sequence number in
// [31:30]; when undefined those bits are constant 2'b00 and no sequence register exists.

module rcs_word_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*28-1:0]   req_data,
    output logic [N_REQ-1:0]      gnt,
    output logic                  busy,
    output logic [31:0]           user_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [1:0]         last_q, last_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [31:0]        word_d;

    logic               win_vld;
    logic [1:0]         win_idx;
    logic [27:0]        win_pay;
    logic [1:0]         seq_cur;

`ifdef RCS_ARB_SEQ_EN
    logic [1:0] seq_q;

    // Sequence advances once per accepted arbitration so a republished
    // identical payload still yields a distinguishable word.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            seq_q <= 2'd0;
        end else if (state_q == IDLE && win_vld) begin
            seq_q <= seq_q + 2'd1;
        end
    end

    assign seq_cur = seq_q;
`else
    assign seq_cur = 2'b00;
`endif

    // Round-robin search: start just above the last winner and wrap.
    always_comb begin
        logic [1:0] cand;
        win_vld = 1'b0;
        win_idx = last_q;
        cand    = 2'd0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = 2'((int'(last_q) + k) % N_REQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Payload of the selected requester.
    always_comb begin
        win_pay = 28'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == 2'(i)) begin
                win_pay = req_data[28*i +: 28];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = '0;
        word_d  = user_data_out;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d        = LOAD;
                    last_d         = win_idx;
                    gnt_d[win_idx] = 1'b1;
                    word_d         = {seq_cur, win_idx, win_pay};
                end
            end
            LOAD: begin
                state_d = HOLD;
                cnt_d   = 8'(HOLD_CYCLES - 1);
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            last_q        <= 2'(N_REQ - 1);
            gnt           <= '0;
            user_data_out <= 32'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            gnt           <= gnt_d;
            user_data_out <= word_d;
        end
    end

    // Derived from the state register so reset clears it asynchronously.
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_rcs_word_arbiter.sv
module tb_rcs_word_arbiter;

    localparam int N_REQ       = 4;
    localparam int HOLD_CYCLES = 16;

    logic                user_clk;
    logic                user_rst_n;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*28-1:0] req_data;
    logic [N_REQ-1:0]    gnt;
    logic                busy;
    logic [31:0]         user_data_out;

    int total = 0;
    int bad   = 0;
    int exp_seq = 0;

    rcs_word_arbiter #(
        .N_REQ       (N_REQ),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .user_clk      (user_clk),
        .user_rst_n    (user_rst_n),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .busy          (busy),
        .user_data_out (user_data_out)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    // Expected published word, given the bench's own sequence count.
    function automatic logic [31:0] mk_word(input int seq, input int id, input logic [27:0] pay);
        logic [1:0] s;
`ifdef RCS_ARB_SEQ_EN
        s = 2'(seq);
`else
        s = 2'b00;
`endif
        return {s, 2'(id), pay};
    endfunction

    task automatic do_reset();
        req        = '0;
        user_rst_n = 1'b0;
        tick();
        tick();
        user_rst_n = 1'b1;
        exp_seq    = 0;
    endtask

    task automatic test_reset();
        req        = '0;
        req_data   = '0;
        user_rst_n = 1'b0;
        tick();
        tick();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || user_data_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_values: gnt=%b busy=%b data=%h, required gnt=0000 busy=0 data=00000000",
                     gnt, busy, user_data_out);
        end
        user_rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || user_data_out !== 32'h0) begin
            bad++;
            $display("FAIL idle_no_req: gnt=%b busy=%b data=%h, required 0000/0/00000000",
                     gnt, busy, user_data_out);
        end
    endtask

    task automatic test_single();
        int busy_cnt;
        logic [31:0] exp;
        do_reset();
        req_data[27:0] = 28'h0ABCDEF;
        req = 4'b0001;
        tick();
        exp = mk_word(exp_seq, 0, 28'h0ABCDEF);
        exp_seq++;
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL single_gnt: gnt=%b, required 0001", gnt);
        end
        total++;
        if (user_data_out !== exp) begin
            bad++;
            $display("FAIL single_word: data=%h, required %h", user_data_out, exp);
        end
        req = 4'b0000;
        busy_cnt = 0;
        for (int c = 0; c < 40 && busy; c++) begin
            busy_cnt++;
            tick();
        end
        total++;
        if (busy_cnt != HOLD_CYCLES + 1) begin
            bad++;
            $display("FAIL single_busy_len: busy cycles=%0d, required %0d", busy_cnt, HOLD_CYCLES + 1);
        end
        total++;
        if (gnt !== 4'b0000) begin
            bad++;
            $display("FAIL single_gnt_once: gnt=%b after grant, required 0000", gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [27:0] pay [4];
        int order [5];
        int cycles;
        logic [31:0] exp;
        order = '{0, 1, 2, 3, 0};
        pay   = '{28'h1111111, 28'h2222222, 28'h3333333, 28'h4444444};
        do_reset();
        for (int i = 0; i < 4; i++) req_data[28*i +: 28] = pay[i];
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            cycles = 0;
            do begin
                tick();
                cycles++;
            end while (gnt === 4'b0000 && cycles < 40);
            total++;
            if (cycles != ((g == 0) ? 1 : HOLD_CYCLES + 2)) begin
                bad++;
                $display("FAIL rr_interval[%0d]: cycles=%0d, required %0d", g, cycles,
                         (g == 0) ? 1 : HOLD_CYCLES + 2);
            end
            exp = mk_word(exp_seq, order[g], pay[order[g]]);
            exp_seq++;
            total++;
            if (gnt !== 4'(1 << order[g]) || user_data_out !== exp) begin
                bad++;
                $display("FAIL rr_grant[%0d]: gnt=%b data=%h, required gnt=%b data=%h",
                         g, gnt, user_data_out, 4'(1 << order[g]), exp);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_mid_hold_request();
        int cycles;
        do_reset();
        req_data[27:0]  = 28'h0000005;
        req_data[83:56] = 28'h7654321;
        req = 4'b0001;
        tick();
        exp_seq++;
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL midhold_first: gnt=%b, required 0001", gnt);
        end
        req = 4'b0000;
        tick();
        tick();
        tick();
        req = 4'b0100;
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (gnt === 4'b0000 && cycles < 40);
        total++;
        if (cycles != HOLD_CYCLES - 1) begin
            bad++;
            $display("FAIL midhold_wait: cycles=%0d, required %0d", cycles, HOLD_CYCLES - 1);
        end
        total++;
        if (gnt !== 4'b0100 || user_data_out !== mk_word(exp_seq, 2, 28'h7654321)) begin
            bad++;
            $display("FAIL midhold_grant: gnt=%b data=%h, required 0100 %h",
                     gnt, user_data_out, mk_word(exp_seq, 2, 28'h7654321));
        end
        exp_seq++;
        req = 4'b0000;
        for (int c = 0; c < 40 && busy; c++) tick();
    endtask

    task automatic test_payload_change();
        logic [31:0] exp;
        int errs;
        req_data[55:28] = 28'h0C0FFEE;
        req = 4'b0010;
        tick();
        exp = mk_word(exp_seq, 1, 28'h0C0FFEE);
        exp_seq++;
        total++;
        if (gnt !== 4'b0010 || user_data_out !== exp) begin
            bad++;
            $display("FAIL latch_grant: gnt=%b data=%h, required 0010 %h", gnt, user_data_out, exp);
        end
        req = 4'b0000;
        errs = 0;
        for (int c = 0; c < HOLD_CYCLES + 6; c++) begin
            req_data[55:28] = 28'(c * 28'h0101010 + 28'h0000077);
            tick();
            if (user_data_out !== exp) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL latch_stable: %0d cycles with data=%h, required %h", errs, user_data_out, exp);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL latch_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [31:0] exp;
        req_data[27:0]  = 28'h0000AAA;
        req_data[111:84] = 28'h0000BBB;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        for (int c = 0; c < 5; c++) tick();
        user_rst_n = 1'b0;
        #1;
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || user_data_out !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: gnt=%b busy=%b data=%h, required 0000/0/00000000",
                     gnt, busy, user_data_out);
        end
        tick();
        user_rst_n = 1'b1;
        exp_seq = 0;
        req = 4'b1001;
        tick();
        exp = mk_word(exp_seq, 0, 28'h0000AAA);
        exp_seq++;
        total++;
        if (gnt !== 4'b0001 || user_data_out !== exp) begin
            bad++;
            $display("FAIL post_reset_first: gnt=%b data=%h, required 0001 %h", gnt, user_data_out, exp);
        end
        req = 4'b1000;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (gnt !== 4'b0000) break;
        end
        exp = mk_word(exp_seq, 3, 28'h0000BBB);
        exp_seq++;
        total++;
        if (gnt !== 4'b1000 || user_data_out !== exp) begin
            bad++;
            $display("FAIL post_reset_second: gnt=%b data=%h, required 1000 %h", gnt, user_data_out, exp);
        end
        req = 4'b0000;
    endtask

    initial begin
        user_rst_n = 1'b0;
        req        = '0;
        req_data   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_mid_hold_request();
        test_payload_change();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
